vmicro16_apb_rr_arbiter: RTL and testbench
==========================================

VMICRO16_APB_RR_ARBITER -- requirements
Module: vmicro16_apb_rr_arbiter

Interface
REQ-001 Parameter CORES, default 4, number of requesting cores (2..8).
REQ-002 Parameter ADDR_W, default 16, APB address width.
REQ-003 Parameter DATA_W, default 16, APB data width.
REQ-004 Parameter TIMEOUT, default 255, maximum ACCESS cycles before forced termination.
REQ-005 The arbiter SHALL have one clock and a synchronous, active-high reset.
REQ-006 clk  in  1  the single clock; all state updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 s_psel  in  CORES  per-core transfer request, one bit per core.
REQ-009 s_paddr  in  CORES*ADDR_W  per-core address; core i occupies slice i.
REQ-010 s_pwrite  in  CORES  per-core write flag.
REQ-011 s_pwdata  in  CORES*DATA_W  per-core write data.
REQ-012 s_prdata  out  DATA_W  read data, shared and valid only with the matching s_pready bit.
REQ-013 s_pready  out  CORES  per-core one-cycle completion pulse.
REQ-014 s_pslverr  out  CORES  per-core error flag, valid with s_pready.
REQ-015 m_psel, m_penable, m_pwrite  out  1 each  APB master controls.
REQ-016 m_paddr  out  ADDR_W; m_pwdata  out  DATA_W  APB master address and write data.
REQ-017 m_prdata  in  DATA_W; m_pready  in  1; m_pslverr  in  1  APB slave response.
REQ-018 grant  out  clog2(CORES)  index of the current owner, for debug.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, SETUP and ACCESS.
REQ-020 IDLE: if any s_psel bit is set, the arbiter SHALL register the winner as the first set bit searching upward from last+1 modulo CORES, then go to SETUP; otherwise it SHALL stay in IDLE.
REQ-021 SETUP: drive m_psel=1, m_penable=0 and the winner's paddr/pwrite/pwdata, then go to ACCESS unconditionally.
REQ-022 ACCESS: drive m_psel=1, m_penable=1 with the same payload; hold until m_pready=1 or the timeout fires.
REQ-023 On m_pready=1 in ACCESS: pulse s_pready[grant] for exactly one cycle with s_prdata=m_prdata and s_pslverr[grant]=m_pslverr, set last=grant, and return to IDLE.
REQ-024 Timeout: a counter SHALL clear on SETUP and increment on each ACCESS cycle; reaching TIMEOUT without m_pready ends the transfer with s_pready[grant]=1, s_pslverr[grant]=1, s_prdata=0, then return to IDLE.
REQ-025 Latency: the minimum is 3 cycles from s_psel to s_pready (IDLE, SETUP, ACCESS with m_pready=1); back-to-back grants have a one-cycle IDLE gap.
REQ-026 The payload SHALL be sampled from the granted core's inputs in SETUP and ACCESS; a core SHALL hold its request stable until its s_pready.
REQ-027 If the granted core drops s_psel mid-transfer, the arbiter SHALL complete the transfer normally.
REQ-028 Requests that arrive simultaneously SHALL be resolved only by round-robin order; no core may be granted twice while another core is continuously requesting.
REQ-029 m_psel, m_penable, s_pready and s_pslverr SHALL be 0 in IDLE; s_pready SHALL have at most one bit set.

Reset
REQ-030 Reset SHALL force the FSM to IDLE, the timeout counter to 0, grant to 0, last to CORES-1 (core 0 has first priority), and all outputs to 0.
REQ-031 Reset during SETUP or ACCESS SHALL abandon the transfer with no s_pready pulse.

Structure
REQ-032 The state encodings and the default TIMEOUT value SHALL live in the shared config header used by the SoC.
REQ-033 The round-robin next-winner search SHALL be one sub-module, vmicro16_rr_pick (inputs: request vector, last; output: winner index and valid), combinational.

Verification
REQ-034 Single request: core 2 writes 0x7008 to 0x0010 with m_pready high immediately -> the master shows SETUP then ACCESS, and s_pready[2] pulses at cycle 3.
REQ-035 All 4 cores request continuously from reset -> grant order is 0,1,2,3,0, and each transfer completes before the next SETUP.
REQ-036 Core 1 reads while the slave holds m_pready low for 5 cycles and then returns 0xBEEF -> s_pready[1] asserts once with s_prdata=0xBEEF.
REQ-037 The slave never asserts m_pready -> after TIMEOUT ACCESS cycles, s_pready[g]=1 and s_pslverr[g]=1, and the FSM returns to IDLE.
REQ-038 Reset asserted in ACCESS -> the next cycle is IDLE, no s_pready pulse occurs, and the following grant goes to core 0.
REQ-039 Core 3 drops s_psel during ACCESS -> the transfer still completes and s_pready[3] pulses.

Source files
------------

// File: rtl/vmicro16_apb_rr_arbiter_pkg.sv
// Shared SoC configuration for the APB round-robin arbiter: FSM state
// encodings and the default ACCESS timeout.
package vmicro16_apb_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/vmicro16_apb_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first requesting core strictly after
// 'last', wrapping modulo CORES, so 'last' itself has the lowest priority.
module vmicro16_rr_pick #(
    parameter int CORES = 4,
    parameter int GW    = 2
) (
    input  logic [CORES-1:0] req,
    input  logic [GW-1:0]    last,
    output logic [GW-1:0]    win,
    output logic             valid
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        win   = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = CORES; k >= 1; k--) begin
            idx = (int'(last) + k) % CORES;
            if (req[idx]) begin
                win   = idx[GW-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vmicro16_apb_rr_arbiter.sv
// Multi-core APB arbiter: round-robin grant of one shared APB master port,
// with an ACCESS-phase timeout that terminates a hung slave with an error.
module vmicro16_apb_rr_arbiter
    import vmicro16_apb_rr_arbiter_pkg::*;
#(
    parameter int CORES   = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    localparam int GW     = (CORES > 1) ? $clog2(CORES) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CORES-1:0]        s_psel,
    input  logic [CORES*ADDR_W-1:0] s_paddr,
    input  logic [CORES-1:0]        s_pwrite,
    input  logic [CORES*DATA_W-1:0] s_pwdata,
    output logic [DATA_W-1:0]       s_prdata,
    output logic [CORES-1:0]        s_pready,
    output logic [CORES-1:0]        s_pslverr,
    output logic                    m_psel,
    output logic                    m_penable,
    output logic                    m_pwrite,
    output logic [ADDR_W-1:0]       m_paddr,
    output logic [DATA_W-1:0]       m_pwdata,
    input  logic [DATA_W-1:0]       m_prdata,
    input  logic                    m_pready,
    input  logic                    m_pslverr,
    output logic [GW-1:0]           grant
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    apb_state_e     state_q;
    logic [GW-1:0]  grant_q;
    logic [GW-1:0]  last_q;
    logic [CW-1:0]  cnt_q;
    logic           m_psel_q;
    logic           m_penable_q;

    logic [GW-1:0]  win_d;
    logic           win_vld_d;
    logic           tmo_d;
    logic           done_d;

    vmicro16_rr_pick #(
        .CORES (CORES),
        .GW    (GW)
    ) u_pick (
        .req   (s_psel),
        .last  (last_q),
        .win   (win_d),
        .valid (win_vld_d)
    );

    // The TIMEOUT-th ACCESS cycle without m_pready ends the transfer.
    assign tmo_d  = (state_q == ST_ACCESS) && (cnt_q == TMO_LAST);
    // Gated by reset so an abandoned transfer never emits a completion.
    assign done_d = (state_q == ST_ACCESS) && (m_pready || tmo_d) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            last_q      <= GW'(CORES - 1);
            cnt_q       <= '0;
            m_psel_q    <= 1'b0;
            m_penable_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_vld_d) begin
                        grant_q  <= win_d;
                        m_psel_q <= 1'b1;
                        state_q  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    cnt_q       <= '0;
                    m_penable_q <= 1'b1;
                    state_q     <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (done_d) begin
                        last_q      <= grant_q;
                        m_psel_q    <= 1'b0;
                        m_penable_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    m_psel_q    <= 1'b0;
                    m_penable_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_psel    = m_psel_q;
    assign m_penable = m_penable_q;
    assign grant     = grant_q;

    // Payload follows the owner's inputs live; responses route back to it.
    always_comb begin
        m_paddr   = '0;
        m_pwrite  = 1'b0;
        m_pwdata  = '0;
        s_pready  = '0;
        s_pslverr = '0;
        s_prdata  = '0;
        for (int i = 0; i < CORES; i++) begin
            if (grant_q == GW'(i)) begin
                if (state_q != ST_IDLE) begin
                    m_paddr  = s_paddr[i*ADDR_W +: ADDR_W];
                    m_pwrite = s_pwrite[i];
                    m_pwdata = s_pwdata[i*DATA_W +: DATA_W];
                end
                if (done_d) begin
                    s_pready[i]  = 1'b1;
                    s_pslverr[i] = m_pready ? m_pslverr : 1'b1;
                end
            end
        end
        if (done_d && m_pready) begin
            s_prdata = m_prdata;
        end
    end

endmodule

// File: tb/tb_vmicro16_apb_rr_arbiter.sv
// Directed bench for the APB round-robin arbiter with hand-computed expectations.
module tb_vmicro16_apb_rr_arbiter;

    localparam int CORES = 4;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int TMO   = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [CORES-1:0]      s_psel;
    logic [CORES*AW-1:0]   s_paddr;
    logic [CORES-1:0]      s_pwrite;
    logic [CORES*DW-1:0]   s_pwdata;
    logic [DW-1:0]         s_prdata;
    logic [CORES-1:0]      s_pready;
    logic [CORES-1:0]      s_pslverr;
    logic                  m_psel;
    logic                  m_penable;
    logic                  m_pwrite;
    logic [AW-1:0]         m_paddr;
    logic [DW-1:0]         m_pwdata;
    logic [DW-1:0]         m_prdata;
    logic                  m_pready;
    logic                  m_pslverr;
    logic [1:0]            grant;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vmicro16_apb_rr_arbiter #(
        .CORES   (CORES),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_psel    (s_psel),
        .s_paddr   (s_paddr),
        .s_pwrite  (s_pwrite),
        .s_pwdata  (s_pwdata),
        .s_prdata  (s_prdata),
        .s_pready  (s_pready),
        .s_pslverr (s_pslverr),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_pwrite  (m_pwrite),
        .m_paddr   (m_paddr),
        .m_pwdata  (m_pwdata),
        .m_prdata  (m_prdata),
        .m_pready  (m_pready),
        .m_pslverr (m_pslverr),
        .grant     (grant)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to the falling edge, just past it, away from the rising edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        s_psel    = '0;
        m_pready  = 1'b0;
        m_pslverr = 1'b0;
        m_prdata  = '0;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        s_paddr  = '0;
        s_pwrite = '0;
        s_pwdata = '0;
        for (int i = 0; i < CORES; i++) begin
            s_paddr[i*AW +: AW]  = 16'h0100 + 16'(i);
            s_pwdata[i*DW +: DW] = 16'hA000 + 16'(i);
        end

        // Reset state, sampled while reset is still held
        reset     = 1'b1;
        s_psel    = '0;
        m_pready  = 1'b0;
        m_pslverr = 1'b0;
        m_prdata  = '0;
        step();
        step();
        check("rst_psel",    32'(m_psel),    32'd0);
        check("rst_penable", 32'(m_penable), 32'd0);
        check("rst_pready",  32'(s_pready),  32'd0);
        check("rst_pslverr", 32'(s_pslverr), 32'd0);
        check("rst_grant",   32'(grant),     32'd0);
        check("rst_prdata",  32'(s_prdata),  32'd0);
        check("rst_paddr",   32'(m_paddr),   32'd0);
        reset = 1'b0;
        #1;

        // Single write from core 2, slave ready immediately
        s_paddr[2*AW +: AW]  = 16'h0010;
        s_pwdata[2*DW +: DW] = 16'h7008;
        s_pwrite[2]          = 1'b1;
        s_psel               = 4'b0100;
        m_pready             = 1'b1;
        m_prdata             = 16'h1234;
        #1;
        check("t1_c1_psel",   32'(m_psel),   32'd0);
        check("t1_c1_pready", 32'(s_pready), 32'd0);
        step();
        check("t1_setup_psel",   32'(m_psel),    32'd1);
        check("t1_setup_pen",    32'(m_penable), 32'd0);
        check("t1_setup_grant",  32'(grant),     32'd2);
        check("t1_setup_paddr",  32'(m_paddr),   32'h0010);
        check("t1_setup_pwdata", 32'(m_pwdata),  32'h7008);
        check("t1_setup_pwrite", 32'(m_pwrite),  32'd1);
        check("t1_setup_pready", 32'(s_pready),  32'd0);
        step();
        check("t1_acc_pen",     32'(m_penable), 32'd1);
        check("t1_acc_paddr",   32'(m_paddr),   32'h0010);
        check("t1_acc_pready",  32'(s_pready),  32'b0100);
        check("t1_acc_pslverr", 32'(s_pslverr), 32'd0);
        s_psel      = '0;
        s_pwrite[2] = 1'b0;
        s_paddr[2*AW +: AW]  = 16'h0102;
        s_pwdata[2*DW +: DW] = 16'hA002;
        step();
        check("t1_idle_psel",   32'(m_psel),   32'd0);
        check("t1_idle_pready", 32'(s_pready), 32'd0);

        // All cores request continuously from reset: grants 0,1,2,3,0
        do_reset();
        s_psel   = 4'b1111;
        m_pready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            step();
            check("t2_setup_grant", 32'(grant),     32'(t % 4));
            check("t2_setup_pen",   32'(m_penable), 32'd0);
            check("t2_setup_paddr", 32'(m_paddr),   32'h0100 + 32'(t % 4));
            step();
            check("t2_acc_pready",  32'(s_pready),  32'd1 << (t % 4));
            step();
            check("t2_idle_psel",   32'(m_psel),    32'd0);
        end

        // Core 1 read with 5 wait states, then 0xBEEF
        do_reset();
        s_psel   = 4'b0010;
        m_pready = 1'b0;
        m_prdata = 16'hDEAD;
        step();
        check("t3_grant", 32'(grant), 32'd1);
        for (int w = 0; w < 5; w++) begin
            step();
            check("t3_wait_pready", 32'(s_pready), 32'd0);
            check("t3_wait_pen",    32'(m_penable), 32'd1);
        end
        step();
        m_pready = 1'b1;
        m_prdata = 16'hBEEF;
        #1;
        check("t3_pready",  32'(s_pready),  32'b0010);
        check("t3_prdata",  32'(s_prdata),  32'hBEEF);
        check("t3_pslverr", 32'(s_pslverr), 32'd0);
        s_psel = '0;
        step();
        check("t3_after_pready", 32'(s_pready), 32'd0);
        check("t3_after_psel",   32'(m_psel),   32'd0);

        // Slave never ready: error termination on the TMO-th ACCESS cycle
        do_reset();
        s_psel   = 4'b1000;
        m_pready = 1'b0;
        m_prdata = 16'hFFFF;
        step();
        check("t4_grant", 32'(grant), 32'd3);
        for (int k = 1; k < TMO; k++) begin
            step();
            check("t4_wait_pready", 32'(s_pready), 32'd0);
        end
        step();
        check("t4_pready",  32'(s_pready),  32'b1000);
        check("t4_pslverr", 32'(s_pslverr), 32'b1000);
        check("t4_prdata",  32'(s_prdata),  32'd0);
        s_psel = '0;
        step();
        check("t4_idle_psel",   32'(m_psel),   32'd0);
        check("t4_idle_pready", 32'(s_pready), 32'd0);

        // Reset in ACCESS abandons the transfer; next grant is core 0
        do_reset();
        s_psel   = 4'b0100;
        m_pready = 1'b0;
        step();
        check("t5_grant", 32'(grant), 32'd2);
        step();
        check("t5_acc_pen", 32'(m_penable), 32'd1);
        reset    = 1'b1;
        m_pready = 1'b1;
        #1;
        check("t5_rst_pready", 32'(s_pready), 32'd0);
        step();
        check("t5_idle_psel",   32'(m_psel),   32'd0);
        check("t5_idle_pready", 32'(s_pready), 32'd0);
        reset  = 1'b0;
        s_psel = 4'b0101;
        step();
        check("t5_next_grant", 32'(grant), 32'd0);
        step();
        check("t5_next_pready", 32'(s_pready), 32'b0001);
        s_psel = '0;
        step();

        // Core 3 drops s_psel mid-transfer; transfer still completes
        do_reset();
        s_paddr[3*AW +: AW] = 16'h0333;
        s_psel   = 4'b1000;
        m_pready = 1'b0;
        step();
        check("t6_grant", 32'(grant), 32'd3);
        step();
        s_psel = '0;
        #1;
        check("t6_drop_pen",   32'(m_penable), 32'd1);
        check("t6_drop_paddr", 32'(m_paddr),   32'h0333);
        check("t6_drop_pready", 32'(s_pready), 32'd0);
        step();
        m_pready = 1'b1;
        m_prdata = 16'h5A5A;
        #1;
        check("t6_pready", 32'(s_pready), 32'b1000);
        check("t6_prdata", 32'(s_prdata), 32'h5A5A);
        step();
        check("t6_idle_psel", 32'(m_psel), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
